capture_ctrl: RTL and testbench

Capture-side controller for the logic analyzer front end. Counts stored samples into the circular sample RAM and raises `armed` once enough pre-trigger history is held. After `triggered` rises it counts the post-trigger samples, then pulses `set_capture_done` to close the capture. It is the producer of `armed`/`set_capture_done` and the consumer of `triggered` from the trigger block, and it drives the write side of the sample RAM.

---
 rtl/la_pkg.sv | 16 +
 rtl/wrap_cntr.sv | 33 +++
 rtl/capture_ctrl.sv | 142 ++++++++++++++
 tb/tb_capture_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared logic analyzer types and defaults
//
// Purpose: capture FSM state type and the default sample RAM depth.
// Shared by the capture controller and the RAM/readout blocks.
package la_pkg;

  // Default depth of the circular sample RAM, in samples.
  localparam int LA_ENTRIES = 384;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/wrap_cntr.sv
// rtl/wrap_cntr.sv - modulo-MOD counter with clear and enable
//
// Purpose: address counter that wraps from MOD-1 back to 0.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset, count -> 0
//   clr    in  synchronous clear to 0, takes priority over en
//   en     in  advance by one, wrapping at MOD-1
//   count  out current count, 0..MOD-1
module wrap_cntr #(
  parameter int MOD = 384,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - logic analyzer capture-side controller
//
// Purpose: drives the write side of the circular sample RAM, raises armed
// once enough pre-trigger history is stored, counts post-trigger samples
// and pulses set_capture_done when the capture is complete.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               start pulse (IDLE only)
//   clr_done          host has read the capture (DONE only)
//   wrt_smpl          a decimated sample is valid this cycle
//   triggered         trigger level from the trigger block
//   trig_pos          post-trigger sample count, sampled at run
//   we, waddr         sample RAM write enable / address
//   armed             pre-trigger history satisfied
//   set_capture_done  one-cycle completion pulse
//   trace_end         address of the last sample written
//   capturing         state is CAPTURE
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = LA_ENTRIES,
  parameter int ADDR_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr_done,
  input  logic              wrt_smpl,
  input  logic              triggered,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              set_capture_done,
  output logic [ADDR_W-1:0] trace_end,
  output logic              capturing
);

  // Counters carry one extra bit so smpl_cnt can reach ENTRIES exactly.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] ENT = CW'(ENTRIES);

  cap_state_t    state;
  logic [CW-1:0] smpl_cnt;
  logic [CW-1:0] trig_cnt;
  logic [CW-1:0] tp_reg;

  logic [CW-1:0] smpl_nxt;
  logic [CW-1:0] trig_nxt;
  logic [CW-1:0] tp_ext;
  logic [CW-1:0] tp_eff;
  logic [CW:0]   arm_sum;
  logic          start;
  logic          trig_hit;

  always_comb begin
    we       = (state == CAPTURE) && wrt_smpl;
    start    = (state == IDLE) && run;
    smpl_nxt = smpl_cnt;
    if (we && (smpl_cnt != ENT)) begin
      smpl_nxt = smpl_cnt + 1'b1;
    end
    arm_sum  = {1'b0, smpl_nxt} + {1'b0, tp_reg};
    // A trigger seen before arming is never counted.
    trig_hit = we && triggered && armed;
    trig_nxt = trig_cnt + 1'b1;
    // Clamp trig_pos to 1..ENTRIES-1.
    tp_ext   = {1'b0, trig_pos};
    if (trig_pos == '0) begin
      tp_eff = CW'(1);
    end else if (tp_ext >= ENT) begin
      tp_eff = ENT - 1'b1;
    end else begin
      tp_eff = tp_ext;
    end
  end

  wrap_cntr #(
    .MOD (ENTRIES),
    .W   (ADDR_W)
  ) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (we),
    .count (waddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      smpl_cnt         <= '0;
      trig_cnt         <= '0;
      tp_reg           <= CW'(1);
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      trace_end        <= '0;
      capturing        <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= CAPTURE;
            capturing <= 1'b1;
            smpl_cnt  <= '0;
            trig_cnt  <= '0;
            tp_reg    <= tp_eff;
            armed     <= 1'b0;
          end
        end
        CAPTURE: begin
          smpl_cnt <= smpl_nxt;
          if (we && (arm_sum >= {1'b0, ENT})) begin
            armed <= 1'b1;
          end
          if (trig_hit) begin
            trig_cnt <= trig_nxt;
            if (trig_nxt == tp_reg) begin
              state            <= DONE;
              capturing        <= 1'b0;
              armed            <= 1'b0;
              set_capture_done <= 1'b1;
              trace_end        <= waddr;
            end
          end
        end
        DONE: begin
          if (clr_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          capturing <= 1'b0;
          armed     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - self-checking bench for capture_ctrl
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       clr_done = 1'b0;
  logic       wrt_smpl = 1'b0;
  logic       triggered = 1'b0;
  logic [3:0] trig_pos = 4'd0;

  logic       we, armed, done, capturing;
  logic [3:0] waddr, trace_end;
  logic       we2, armed2, done2, capturing2;
  logic [3:0] waddr2, trace_end2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  capture_ctrl #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_done(clr_done),
    .wrt_smpl(wrt_smpl), .triggered(triggered), .trig_pos(trig_pos),
    .we(we), .waddr(waddr), .armed(armed), .set_capture_done(done),
    .trace_end(trace_end), .capturing(capturing)
  );

  // Second depth so trig_pos can exceed ENTRIES-1 within 4 bits.
  capture_ctrl #(.ENTRIES(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_done(clr_done),
    .wrt_smpl(wrt_smpl), .triggered(triggered), .trig_pos(trig_pos),
    .we(we2), .waddr(waddr2), .armed(armed2), .set_capture_done(done2),
    .trace_end(trace_end2), .capturing(capturing2)
  );

  // A correct trigger block never asserts triggered before armed.
  always @(negedge clk) begin
    if (rst_n && capturing && triggered && !armed) begin
      fails++;
      $display("FAIL trig_unarmed: triggered=1 while armed=0 at %0t", $time);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 0; clr_done = 0; wrt_smpl = 0; triggered = 0;
    trig_pos = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start(input logic [3:0] tp);
    trig_pos = tp; run = 1'b1; wrt_smpl = 1'b0;
    tick();
    run = 1'b0;
  endtask

  typedef struct {
    int run, clr, wr, trig, tp;
    int e_we, e_waddr, e_armed, e_done, e_cap;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 6,  0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 6,  1, 0, 0, 0, 1};
    tbl[4] = '{0, 0, 1, 0, 6,  1, 1, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 6,  0, 2, 0, 0, 1};
    tbl[6] = '{0, 1, 1, 0, 6,  1, 2, 0, 0, 1};
    tbl[7] = '{1, 0, 0, 0, 6,  0, 3, 0, 0, 1};
    tbl[8] = '{0, 0, 0, 0, 6,  0, 3, 0, 0, 1};

    // Reset state, held in reset.
    #2;
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trace_end", int'(trace_end), 0);
    chk("rst_capturing", int'(capturing), 0);

    // Table: idle behaviour, start, ignored clr_done/run in CAPTURE.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run = 1'(tbl[i].run); clr_done = 1'(tbl[i].clr);
      wrt_smpl = 1'(tbl[i].wr); triggered = 1'(tbl[i].trig);
      trig_pos = 4'(tbl[i].tp);
      #1;
      chk($sformatf("tbl%0d_we", i), int'(we), tbl[i].e_we);
      chk($sformatf("tbl%0d_waddr", i), int'(waddr), tbl[i].e_waddr);
      chk($sformatf("tbl%0d_armed", i), int'(armed), tbl[i].e_armed);
      chk($sformatf("tbl%0d_done", i), int'(done), tbl[i].e_done);
      chk($sformatf("tbl%0d_cap", i), int'(capturing), tbl[i].e_cap);
      tick();
    end

    // Arming and full capture: trig_pos 6, trigger after 12th write.
    do_reset();
    start(4'd6);
    for (int i = 1; i <= 18; i++) begin
      wrt_smpl = 1'b1; triggered = (i > 12);
      #1;
      chk("cap_waddr", int'(waddr), (i - 1) % 16);
      chk("cap_we", int'(we), 1);
      chk("cap_armed", int'(armed), int'(i >= 11));
      chk("cap_done_early", int'(done), 0);
      tick();
    end
    #1;
    chk("cap_done", int'(done), 1);
    chk("cap_done_capturing", int'(capturing), 0);
    chk("cap_trace_end", int'(trace_end), 1);
    chk("cap_done_we", int'(we), 0);
    chk("cap_done_armed", int'(armed), 0);
    tick();
    triggered = 1'b0;
    #1;
    chk("cap_done_pulse", int'(done), 0);
    chk("cap_waddr_hold", int'(waddr), 2);
    chk("cap_done_we2", int'(we), 0);
    tick();
    // Clear and restart.
    wrt_smpl = 1'b0; clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
    #1;
    chk("clr_idle", int'(capturing), 0);
    chk("clr_waddr_hold", int'(waddr), 2);
    start(4'd6);
    wrt_smpl = 1'b1;
    #1;
    chk("rerun_waddr", int'(waddr), 0);
    chk("rerun_we", int'(we), 1);
    chk("rerun_cap", int'(capturing), 1);
    chk("rerun_armed", int'(armed), 0);

    // Wrap: 40 pre-trigger writes then 6 post-trigger writes.
    do_reset();
    start(4'd6);
    for (int i = 1; i <= 46; i++) begin
      wrt_smpl = 1'b1; triggered = (i > 40);
      #1;
      chk("wrap_waddr", int'(waddr), (i - 1) % 16);
      chk("wrap_armed", int'(armed), int'(i >= 11));
      tick();
    end
    #1;
    chk("wrap_done", int'(done), 1);
    chk("wrap_trace_end", int'(trace_end), 13);
    triggered = 1'b0; wrt_smpl = 1'b0;

    // trig_pos 0 acts as 1: armed after 15 writes, done after 1 more.
    do_reset();
    start(4'd0);
    for (int i = 1; i <= 16; i++) begin
      wrt_smpl = 1'b1; triggered = (i == 16);
      #1;
      chk("tp0_armed", int'(armed), int'(i >= 16));
      tick();
    end
    #1;
    chk("tp0_done", int'(done), 1);
    chk("tp0_trace_end", int'(trace_end), 15);
    chk("tp0_done_b", int'(done2), 1);
    chk("tp0_trace_end_b", int'(trace_end2), 3);
    triggered = 1'b0; wrt_smpl = 1'b0;

    // trig_pos 15: legal max at depth 16, clamped to 11 at depth 12.
    do_reset();
    start(4'd15);
    wrt_smpl = 1'b1;
    tick();
    #1;
    chk("tp15_armed", int'(armed), 1);
    chk("tp15_armed_b", int'(armed2), 1);
    for (int k = 1; k <= 15; k++) begin
      triggered = 1'b1;
      #1;
      chk("tp15_busy", int'(capturing), 1);
      chk("tp15_done_early", int'(done), 0);
      chk("tp15_done_b", int'(done2), int'(k == 12));
      tick();
    end
    #1;
    chk("tp15_done", int'(done), 1);
    chk("tp15_trace_end", int'(trace_end), 15);
    chk("tp15_trace_end_b", int'(trace_end2), 11);
    triggered = 1'b0; wrt_smpl = 1'b0;

    // Reset mid-capture with triggered high.
    do_reset();
    start(4'd6);
    for (int i = 1; i <= 15; i++) begin
      wrt_smpl = 1'b1; triggered = (i > 12);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cap", int'(capturing), 0);
    chk("mid_rst_armed", int'(armed), 0);
    chk("mid_rst_waddr", int'(waddr), 0);
    chk("mid_rst_we", int'(we), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_done", int'(done), 0);
    end
    triggered = 1'b0; wrt_smpl = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_cap", int'(capturing), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
